// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
// Time-multiplexed multi-digit 7-segment driver. BCD digits are held in a
// pending/active double buffer so the shown value only changes between frames.
// One digit is shown per slot of CLK_DIV clocks; the first BLANK_CYCLES clocks
// of each slot keep every anode off to suppress ghosting. All outputs are
// registered, one clock behind the scan state.

module seven_seg_scan_driver #(
    parameter int N_DIGITS       = 4,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 0,
    parameter bit ACTIVE_LOW_OUT = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] bcd_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lzb,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_start
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int IW = $clog2(N_DIGITS);

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic                    tick;
    logic                    boundary;

    logic [4*N_DIGITS-1:0]   pend_bcd;
    logic [N_DIGITS-1:0]     pend_dp;
    logic                    pend_flag;
    logic [4*N_DIGITS-1:0]   act_bcd;
    logic [N_DIGITS-1:0]     act_dp;

    logic [N_DIGITS-1:0]     supp;
    logic [3:0]              cur_digit;
    logic                    show;
    logic [6:0]              seg_d;
    logic                    dp_d;
    logic [N_DIGITS-1:0]     an_d;

    // Internal outputs are active-high; polarity is applied after the flops.
    logic [6:0]              seg_q;
    logic                    dp_q;
    logic [N_DIGITS-1:0]     an_q;
    logic                    wrap_q;
    logic                    fs_q;

    assign tick     = en && (cnt == CW'(CLK_DIV - 1));
    assign boundary = tick && (idx == IW'(N_DIGITS - 1));

    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1101111;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

    // Prescaler and digit index; both freeze while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (en) begin
            if (tick) begin
                cnt <= '0;
                if (idx == IW'(N_DIGITS - 1))
                    idx <= '0;
                else
                    idx <= idx + IW'(1);
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    // Double buffer: a load on the boundary cycle goes straight to active,
    // otherwise loads park in pending and are promoted at the next boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_bcd  <= '0;
            pend_dp   <= '0;
            pend_flag <= 1'b0;
            act_bcd   <= '0;
            act_dp    <= '0;
        end else if (boundary && load) begin
            act_bcd   <= bcd_in;
            act_dp    <= dp_in;
            pend_flag <= 1'b0;
        end else if (boundary && pend_flag) begin
            act_bcd   <= pend_bcd;
            act_dp    <= pend_dp;
            pend_flag <= 1'b0;
        end else if (load) begin
            pend_bcd  <= bcd_in;
            pend_dp   <= dp_in;
            pend_flag <= 1'b1;
        end
    end

    // Leading-zero suppression: a digit is dropped when it and every digit
    // above it are zero. Digit 0 always shows.
    always_comb begin
        logic zero_above;
        supp       = '0;
        zero_above = lzb;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            zero_above = zero_above && (act_bcd[4*k +: 4] == 4'd0);
            supp[k]    = zero_above;
        end
    end

    // Next output values for the digit currently selected by idx.
    always_comb begin
        cur_digit = act_bcd[4*int'(idx) +: 4];
        show      = en && (int'(cnt) >= BLANK_CYCLES) && !supp[idx];
        an_d      = '0;
        seg_d     = 7'b0000000;
        dp_d      = 1'b0;
        if (show) begin
            an_d[idx] = 1'b1;
            seg_d     = decode(cur_digit);
            dp_d      = act_dp[idx];
        end
    end

    // Output registers; frame_start lines up with the first output of slot 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q  <= '0;
            dp_q   <= 1'b0;
            an_q   <= '0;
            wrap_q <= 1'b0;
            fs_q   <= 1'b0;
        end else begin
            seg_q  <= seg_d;
            dp_q   <= dp_d;
            an_q   <= an_d;
            wrap_q <= boundary;
            fs_q   <= wrap_q;
        end
    end

    assign seg         = seg_q ^ {7{ACTIVE_LOW_OUT}};
    assign dp          = dp_q ^ ACTIVE_LOW_OUT;
    assign an          = an_q ^ {N_DIGITS{ACTIVE_LOW_OUT}};
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for seven_seg_scan_driver with N_DIGITS=4, CLK_DIV=8,
// BLANK_CYCLES=2 and active-high outputs. Expected patterns are hand-written
// constants; each slot is checked clock by clock.

module tb_seven_seg_scan_driver;

    localparam logic [6:0] P0 = 7'b0111111;
    localparam logic [6:0] P1 = 7'b0000110;
    localparam logic [6:0] P2 = 7'b1011011;
    localparam logic [6:0] P3 = 7'b1001111;
    localparam logic [6:0] P4 = 7'b1100110;
    localparam logic [6:0] P5 = 7'b1101101;
    localparam logic [6:0] P6 = 7'b1111101;
    localparam logic [6:0] P7 = 7'b0000111;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] PB = 7'b0000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic        lzb;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int          n_pass  = 0;
    int          n_total = 0;
    bit          fs_armed = 1'b0;
    logic [15:0] ld_bcd;
    logic [3:0]  ld_dp;

    seven_seg_scan_driver #(
        .N_DIGITS      (4),
        .CLK_DIV       (8),
        .BLANK_CYCLES  (2),
        .ACTIVE_LOW_OUT(1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .bcd_in     (bcd_in),
        .dp_in      (dp_in),
        .lzb        (lzb),
        .seg        (seg),
        .dp         (dp),
        .an         (an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_off(input string tag);
        chk({tag, " an"},  32'(an),          32'h0);
        chk({tag, " seg"}, 32'(seg),         32'h0);
        chk({tag, " dp"},  32'(dp),          32'h0);
        chk({tag, " fs"},  32'(frame_start), 32'h0);
    endtask

    // One clock of slot k at count c; vis=0 means the digit is suppressed.
    task automatic cyc(input int k, input int c, input bit vis,
                       input logic [6:0] pat, input bit dpv);
        logic       on;
        logic [3:0] ean;
        logic [6:0] eseg;
        logic       edp;
        logic       efs;
        string      t;
        @(posedge clk);
        #1;
        load = 1'b0;
        on   = vis && (c >= 2);
        ean  = on ? (4'b0001 << k) : 4'b0000;
        eseg = on ? pat : 7'b0000000;
        edp  = on ? dpv : 1'b0;
        efs  = (k == 0) && (c == 0) && fs_armed;
        t    = $sformatf("s%0d c%0d", k, c);
        chk({t, " an"},  32'(an),          32'(ean));
        chk({t, " seg"}, 32'(seg),         32'(eseg));
        chk({t, " dp"},  32'(dp),          32'(edp));
        chk({t, " fs"},  32'(frame_start), 32'(efs));
        if (k == 3 && c == 7)
            fs_armed = 1'b1;
    endtask

    // Whole slot; ld_last arms a load on the final (boundary) clock.
    task automatic slot(input int k, input bit vis, input logic [6:0] pat,
                        input bit dpv, input bit ld_last);
        for (int c = 0; c < 8; c++) begin
            cyc(k, c, vis, pat, dpv);
            if (ld_last && c == 6) begin
                bcd_in = ld_bcd;
                dp_in  = ld_dp;
                load   = 1'b1;
            end
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        en     = 1'b0;
        load   = 1'b0;
        bcd_in = 16'h0000;
        dp_in  = 4'b0000;
        lzb    = 1'b0;
        ld_bcd = 16'h0000;
        ld_dp  = 4'b0000;

        repeat (3) @(posedge clk);
        #1;
        chk_off("reset");

        // Frame A shows reset value 0000; 0x1234 goes to pending.
        rst_n  = 1'b1;
        en     = 1'b1;
        bcd_in = 16'h1234;
        load   = 1'b1;
        slot(0, 1, P0, 0, 0);
        slot(1, 1, P0, 0, 0);
        slot(2, 1, P0, 0, 0);
        slot(3, 1, P0, 0, 0);

        // Frame B shows 1234; a mid-frame load of 5678 must not show yet.
        slot(0, 1, P4, 0, 0);
        bcd_in = 16'h5678;
        load   = 1'b1;
        slot(1, 1, P3, 0, 0);
        slot(2, 1, P2, 0, 0);
        slot(3, 1, P1, 0, 0);

        // Frame C shows 5678; load 4321 on the boundary cycle.
        ld_bcd = 16'h4321;
        ld_dp  = 4'b0000;
        slot(0, 1, P8, 0, 0);
        slot(1, 1, P7, 0, 0);
        slot(2, 1, P6, 0, 0);
        slot(3, 1, P5, 0, 1);

        // Frame D shows 4321 straight away; boundary-load 0x0070.
        ld_bcd = 16'h0070;
        slot(0, 1, P1, 0, 0);
        slot(1, 1, P2, 0, 0);
        slot(2, 1, P3, 0, 0);
        slot(3, 1, P4, 0, 1);

        // Frame E: 0x0070 with blanking; digits 3 and 2 suppressed.
        lzb    = 1'b1;
        ld_bcd = 16'h0000;
        slot(0, 1, P0, 0, 0);
        slot(1, 1, P7, 0, 0);
        slot(2, 0, PB, 0, 0);
        slot(3, 0, PB, 0, 1);

        // Frame F: 0x0000 with blanking; only digit 0 shows.
        ld_bcd = 16'h0A00;
        ld_dp  = 4'b0100;
        slot(0, 1, P0, 0, 0);
        slot(1, 0, PB, 0, 0);
        slot(2, 0, PB, 0, 0);
        slot(3, 0, PB, 0, 1);

        // Frame G: 0x0A00, dp on digit 2, blanking off -> all anodes scan.
        lzb = 1'b0;
        slot(0, 1, P0, 0, 0);
        slot(1, 1, P0, 0, 0);
        slot(2, 1, PB, 1, 0);
        slot(3, 1, P0, 0, 0);

        // Frame H: en dropped for 20 clocks in slot 0 after count 3.
        for (int c = 0; c < 4; c++) cyc(0, c, 1, P0, 0);
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            chk_off($sformatf("en_off %0d", i));
        end
        en = 1'b1;
        for (int c = 4; c < 8; c++) cyc(0, c, 1, P0, 0);
        slot(1, 1, P0, 0, 0);
        slot(2, 1, PB, 1, 0);
        slot(3, 1, P0, 0, 0);

        // Frame I: reset pulsed in slot 2 while digit 2 is lit.
        slot(0, 1, P0, 0, 0);
        slot(1, 1, P0, 0, 0);
        for (int c = 0; c < 3; c++) cyc(2, c, 1, PB, 1);
        rst_n = 1'b0;
        #1;
        chk_off("async_rst");
        fs_armed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_off("in_rst");
        rst_n = 1'b1;

        // After release the scan restarts at slot 0 showing 0000.
        slot(0, 1, P0, 0, 0);
        slot(1, 1, P0, 0, 0);
        slot(2, 1, P0, 0, 0);
        slot(3, 1, P0, 0, 0);
        cyc(0, 0, 1, P0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
